// File: rtl/jmp_pkg.sv
// Shared types and constants for the jump sequencer and its condition evaluator.
package jmp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_HI = 2'd1,
        FETCH_LO = 2'd2,
        EXEC     = 2'd3
    } state_t;

    localparam int COND_ALWAYS = 0;
    localparam int COND_EQ     = 1;
    localparam int COND_NE     = 2;
    localparam int COND_LTU    = 3;
    localparam int COND_LEU    = 4;
    localparam int COND_GTU    = 5;
    localparam int COND_GEU    = 6;
    localparam int COND_LT     = 7;
    localparam int COND_LE     = 8;
    localparam int COND_GT     = 9;
    localparam int COND_GE     = 10;

    // The jump instruction is opcode, operand high byte, operand low byte.
    localparam int OFS_HI   = 1;
    localparam int OFS_LO   = 2;
    localparam int INSN_LEN = 3;

endpackage

// File: rtl/jmp_cond.sv
// Combinational branch-condition evaluator: condition code plus ALU flags -> taken.
module jmp_cond
    import jmp_pkg::*;
#(
    parameter int COND_W = 4
) (
    input  logic [COND_W-1:0] cond_sel,
    input  logic              zflag,
    input  logic              cflag,
    input  logic              oflag,
    input  logic              sflag,
    output logic              taken
);

    logic lt_signed;

    assign lt_signed = oflag ^ sflag;

    // Unassigned codes fall to the default and are never taken.
    always_comb begin
        taken = 1'b0;
        case (cond_sel)
            COND_W'(COND_ALWAYS): taken = 1'b1;
            COND_W'(COND_EQ):     taken = zflag;
            COND_W'(COND_NE):     taken = ~zflag;
            COND_W'(COND_LTU):    taken = cflag;
            COND_W'(COND_LEU):    taken = cflag | zflag;
            COND_W'(COND_GTU):    taken = ~(cflag | zflag);
            COND_W'(COND_GEU):    taken = ~cflag;
            COND_W'(COND_LT):     taken = lt_signed;
            COND_W'(COND_LE):     taken = lt_signed | zflag;
            COND_W'(COND_GT):     taken = ~lt_signed & ~zflag;
            COND_W'(COND_GE):     taken = ~lt_signed;
            default:              taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/jmp_seq.sv
// Multi-cycle jump sequencer: resolves the condition, fetches the 16-bit operand
// over a req/ack port, then issues a one-cycle PC load.
module jmp_seq
    import jmp_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int COND_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COND_W-1:0] cond_sel,
    input  logic              rel,
    input  logic              zflag,
    input  logic              cflag,
    input  logic              oflag,
    input  logic              sflag,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              taken,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_l;
    logic              rel_l;
    logic              taken_l;
    logic [7:0]        hi;
    logic [7:0]        lo;
    logic              cond_taken;
    logic [ADDR_W-1:0] fall_through;
    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] target;

    jmp_cond #(
        .COND_W (COND_W)
    ) u_cond (
        .cond_sel (cond_sel),
        .zflag    (zflag),
        .cflag    (cflag),
        .oflag    (oflag),
        .sflag    (sflag),
        .taken    (cond_taken)
    );

    assign fall_through = pc_l + ADDR_W'(INSN_LEN);
    assign operand      = ADDR_W'({hi, lo});
    assign target       = rel_l ? (fall_through + operand) : operand;

    // The condition is resolved at start, so only its result needs to be kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc_l    <= '0;
            rel_l   <= 1'b0;
            taken_l <= 1'b0;
            hi      <= 8'h00;
            lo      <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                pc_l    <= pc;
                rel_l   <= rel;
                taken_l <= cond_taken;
                hi      <= 8'h00;
                lo      <= 8'h00;
            end
            if (state == FETCH_HI && mem_ack) hi <= mem_data;
            if (state == FETCH_LO && mem_ack) lo <= mem_data;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        pc_load   = 1'b0;
        pc_next   = '0;
        taken     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = cond_taken ? FETCH_HI : EXEC;
            end
            FETCH_HI: begin
                mem_req  = 1'b1;
                mem_addr = pc_l + ADDR_W'(OFS_HI);
                if (mem_ack) state_nxt = FETCH_LO;
            end
            FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = pc_l + ADDR_W'(OFS_LO);
                if (mem_ack) state_nxt = EXEC;
            end
            EXEC: begin
                pc_load   = 1'b1;
                taken     = taken_l;
                pc_next   = taken_l ? target : fall_through;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/jmp_seq.md
Name: jmp_seq

Overview:
- Multi-cycle sequencer for conditional and unconditional jump instructions.
- Started by the decoder. Evaluates the branch condition from the ALU flags, fetches the 16-bit operand (high byte, then low byte) over a req/ack memory port, and forms an absolute or PC-relative target.
- Issues a single-cycle PC load, then hands control back to the decoder.

Parameters:
- ADDR_W, 16, PC/address width.
- COND_W, 4, width of the condition-select field.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  jump decoded; sampled only in IDLE.
- cond_sel  in  COND_W  condition code; sampled with start.
- rel  in  1  1 = PC-relative target, 0 = absolute; sampled with start.
- zflag, cflag, oflag, sflag  in  1 each  ALU flags; sampled with start.
- pc  in  ADDR_W  address of the jump opcode; sampled with start.
- mem_req  out  1  operand read request.
- mem_addr  out  ADDR_W  operand read address.
- mem_ack  in  1  read complete; mem_data valid in the same cycle.
- mem_data  in  8  read data.
- pc_load  out  1  one-cycle strobe: load pc_next into PC.
- pc_next  out  ADDR_W  next PC value; 0 when pc_load = 0.
- taken  out  1  condition result; valid with pc_load, 0 otherwise.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0; latched registers cleared. Reset mid-operation abandons the jump; no pc_load is issued.
- States: IDLE, FETCH_HI, FETCH_LO, EXEC.
- IDLE, start = 1:
  - Latch cond_sel, rel, flags, pc.
  - Condition taken -> FETCH_HI.
  - Condition not taken -> EXEC with target pc+3 and no memory traffic.
- FETCH_HI:
  - mem_req = 1, mem_addr = pc_l+1.
  - On mem_ack, capture mem_data into hi -> FETCH_LO.
- FETCH_LO:
  - mem_req = 1, mem_addr = pc_l+2.
  - On mem_ack, capture lo -> EXEC.
- EXEC (one cycle):
  - pc_load = 1, taken driven.
  - pc_next = taken ? (rel ? pc_l+3+{hi,lo} : {hi,lo}) : pc_l+3.
  - Next state IDLE.
- Handshake rules:
  - mem_req and mem_addr are Moore outputs, stable until ack is sampled.
  - Ack is allowed in the first request cycle (zero-wait).
  - Ack outside FETCH_HI/FETCH_LO is ignored.
- Arithmetic: all address sums are modulo 2^ADDR_W. Example: pc = FFFF fetches from 0000 and 0001; not-taken target is 0002.
- Latency, start accepted at cycle T:
  - Not taken: pc_load at T+1.
  - Taken, zero-wait: pc_load at T+3.
  - Each wait cycle adds 1.
- start while busy (including the EXEC cycle) is ignored, not queued.
- Condition codes:
  - 0 always
  - 1 eq: z
  - 2 ne: !z
  - 3 ltu: c
  - 4 leu: c|z
  - 5 gtu: !(c|z)
  - 6 geu: !c
  - 7 lt: o^s
  - 8 le: (o^s)|z
  - 9 gt: !(o^s)&!z
  - 10 ge: !(o^s)
  - 11–15: never taken (treated as not taken)

Decomposition:
- Shared package jmp_pkg:
  - State enum.
  - Condition-code constants COND_ALWAYS..COND_GE.
  - Operand byte offsets OFS_HI = 1, OFS_LO = 2, INSN_LEN = 3.
- One natural sub-module: jmp_cond, a combinational evaluator (cond_sel, flags -> taken). It is reused by any future conditional-call logic.

Test Plan:
- Absolute, always taken:
  - Stimulus: cond 0, rel 0, pc 0100, mem[0101] = 12, mem[0102] = 34, zero-wait ack.
  - Response: mem_addr 0101 then 0102; pc_load at T+3; pc_next 1234; taken 1.
- Not taken:
  - Stimulus: cond 1, z = 0, pc 0200.
  - Response: mem_req never asserted; pc_load at T+1; pc_next 0203; taken 0.
- Relative with wrap:
  - Stimulus: cond 0, rel 1, pc FFF0, operand 0020.
  - Response: pc_next 0013.
  - Second case: pc FFFF, operand 0000 -> fetches at 0000/0001; pc_next 0002.
- Wait states:
  - Stimulus: ack delayed 3 cycles on each byte.
  - Response: mem_req/mem_addr held stable throughout; pc_load at T+9; pc_next correct.
- Signed conditions, flags o = 1, s = 0, z = 0:
  - cond 7 and cond 8 taken.
  - cond 9 and cond 10 not taken.
  - cond 15 not taken.
- Reset and busy:
  - Assert rst during FETCH_LO -> busy 0, mem_req 0, no pc_load afterwards.
  - start pulsed during FETCH_HI -> ignored; exactly one pc_load for the original jump.
